// File: rtl/alu_serial_seq_if.sv
// Handshake/operand bundle between the datapath controller (master)
// and the bit-serial ALU sequencer (slave).
interface alu_serial_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       ALUOp;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             CarryOut;
  logic             zero;
  logic             overflow;
  logic             err;

  modport master (
    output start, ALUOp, a, b,
    input  busy, done, result, CarryOut, zero, overflow, err
  );

  modport slave (
    input  start, ALUOp, a, b,
    output busy, done, result, CarryOut, zero, overflow, err
  );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: feeds one operand bit per clock (LSB first) through
// a single ALU_1_bit slice and assembles a WIDTH-bit result with flags.

module ALU_1_bit (
  input  logic       a,
  input  logic       b,
  input  logic       CarryIn,
  input  logic [3:0] ALUOp,
  output logic       result,
  output logic       CarryOut
);
  logic a_eff;
  logic b_eff;
  logic sum;

  // ALUOp[3]/[2] invert A/B; ALUOp[1:0] selects AND/OR/ADD.
  assign a_eff    = a ^ ALUOp[3];
  assign b_eff    = b ^ ALUOp[2];
  assign sum      = a_eff ^ b_eff ^ CarryIn;
  assign CarryOut = (a_eff & b_eff) | (a_eff & CarryIn) | (b_eff & CarryIn);

  always_comb begin
    result = 1'b0;
    case (ALUOp[1:0])
      2'b00:   result = a_eff & b_eff;
      2'b01:   result = a_eff | b_eff;
      2'b10:   result = sum;
      default: result = 1'b0;
    endcase
  end
endmodule

module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  alu_serial_seq_if.slave   bus
);
  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic sl_a;
  logic sl_b;
  logic sl_res;
  logic sl_co;
  logic op_supported;
  logic op_arith;

  assign sl_a = a_q[idx_q];
  assign sl_b = b_q[idx_q];

  ALU_1_bit u_slice (
    .a        (sl_a),
    .b        (sl_b),
    .CarryIn  (carry_q),
    .ALUOp    (op_q),
    .result   (sl_res),
    .CarryOut (sl_co)
  );

  always_comb begin
    op_supported = 1'b0;
    case (bus.ALUOp)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR: op_supported = 1'b1;
      default:                               op_supported = 1'b0;
    endcase
  end

  assign op_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      co_q     <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      co_q     <= co_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    co_d     = co_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          op_d     = bus.ALUOp;
          idx_d    = '0;
          carry_d  = (bus.ALUOp == OP_SUB);
          result_d = '0;
          co_d     = 1'b0;
          ovf_d    = 1'b0;
          zero_d   = 1'b1;
          err_d    = !op_supported;
          state_d  = op_supported ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        result_d[idx_q] = sl_res;
        carry_d         = sl_co;
        idx_d           = idx_q + IW'(1);
        if (idx_q == IW'(WIDTH - 1)) begin
          // carry_q is the carry into the MSB; sl_co the carry out of it.
          co_d    = op_arith & sl_co;
          ovf_d   = op_arith & (carry_q ^ sl_co);
          zero_d  = (result_d == '0);
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy     = (state_q == S_RUN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.result   = result_q;
  assign bus.CarryOut = co_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed + randomized bench for alu_serial_seq with an arithmetic reference model.
module tb_alu_serial_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  alu_serial_seq_if #(.WIDTH(W)) bus ();

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic, independent of the bit-serial datapath.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic [3:0] op,
                       output logic [7:0] r, output logic co, output logic ovf,
                       output logic z, output logic e, output int lat);
    logic [8:0] wide;
    r = 8'h00; co = 1'b0; ovf = 1'b0; e = 1'b0; lat = W;
    case (op)
      4'b0000: r = ma & mb;
      4'b0001: r = ma | mb;
      4'b1100: r = ~(ma | mb);
      4'b0010: begin
        wide = {1'b0, ma} + {1'b0, mb};
        r = wide[7:0]; co = wide[8];
        ovf = (ma[7] == mb[7]) && (r[7] != ma[7]);
      end
      4'b0110: begin
        wide = {1'b0, ma} - {1'b0, mb};
        r = wide[7:0]; co = (ma >= mb);
        ovf = (ma[7] != mb[7]) && (r[7] != ma[7]);
      end
      default: begin e = 1'b1; lat = 0; end
    endcase
    z = (r == 8'h00);
  endtask

  task automatic drive_start(input logic [7:0] ta, input logic [7:0] tb_, input logic [3:0] op);
    bus.start = 1'b1; bus.a = ta; bus.b = tb_; bus.ALUOp = op;
  endtask

  // Call at a negedge just after the accept edge; returns cycles until done is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) chk("done_timeout", 32'(bus.done), 32'd1);
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                               input logic [3:0] op, input int lat);
    logic [7:0] r; logic co, ovf, z, e; int elat;
    model(ta, tb_, op, r, co, ovf, z, e, elat);
    chk({tag, "_lat"},    32'(lat), 32'(elat));
    chk({tag, "_result"}, 32'(bus.result), 32'(r));
    chk({tag, "_carry"},  32'(bus.CarryOut), 32'(co));
    chk({tag, "_ovf"},    32'(bus.overflow), 32'(ovf));
    chk({tag, "_zero"},   32'(bus.zero), 32'(z));
    chk({tag, "_err"},    32'(bus.err), 32'(e));
  endtask

  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic [3:0] op);
    int lat;
    logic [7:0] r; logic co, ovf, z, e; int elat;
    model(ta, tb_, op, r, co, ovf, z, e, elat);
    @(negedge clk);
    drive_start(ta, tb_, op);
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'(!e));
    wait_done(lat);
    check_outputs(tag, ta, tb_, op, lat);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_hold"},  32'(bus.result), 32'(r));
  endtask

  initial begin
    int lat;
    logic [3:0] ops [6];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0011};

    reset = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.ALUOp = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd1);
    chk("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b0;

    run_op("add_ovf", 8'h7F, 8'h01, 4'b0010);
    run_op("sub_eq", 8'h05, 8'h05, 4'b0110);
    run_op("sub_neg", 8'h00, 8'h01, 4'b0110);
    run_op("and", 8'hF0, 8'h3C, 4'b0000);
    run_op("or", 8'hF0, 8'h3C, 4'b0001);
    run_op("nor", 8'hF0, 8'h3C, 4'b1100);
    run_op("bad_op", 8'h12, 8'h34, 4'b0011);
    run_op("err_clr", 8'h10, 8'h20, 4'b0010);

    // Start during RUN is ignored.
    @(negedge clk);
    drive_start(8'h33, 8'h44, 4'b0010);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    drive_start(8'hAA, 8'hAA, 4'b0110);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 3;
    while (bus.done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    check_outputs("ignore", 8'h33, 8'h44, 4'b0010, lat);

    // Start in the DONE cycle: RUN with no idle gap.
    drive_start(8'hC8, 8'h64, 4'b0010);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    chk("b2b_done", 32'(bus.done), 32'd0);
    wait_done(lat);
    check_outputs("b2b", 8'hC8, 8'h64, 4'b0010, lat);
    @(negedge clk);

    // Asynchronous reset mid-RUN.
    drive_start(8'hFF, 8'hFF, 4'b0010);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_result", 32'(bus.result), 32'd0);
    chk("arst_zero", 32'(bus.zero), 32'd1);
    chk("arst_carry", 32'(bus.CarryOut), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    lat = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) lat++;
    end
    chk("arst_nodone", 32'(lat), 32'd0);
    run_op("post_rst", 8'h2B, 8'h19, 4'b0010);

    for (int i = 0; i < 30; i++) begin
      run_op("rand", 8'($urandom), 8'($urandom), ops[$urandom_range(0, 5)]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
